// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
// ps2_host_tx: PS/2 host-to-device command transmitter.
// Inhibits the bus, issues a request-to-send, shifts a byte plus odd parity and checks the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 1500,
  parameter int TIMEOUT_CYCLES = 30000
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_din,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQUEST,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t           r_state;
  logic             r_clkMeta;
  logic             r_clkSync;
  logic             r_clkPrev;
  logic             r_datMeta;
  logic             r_datSync;
  logic [7:0]       r_data;
  logic             r_parity;
  logic [3:0]       r_edgeCnt;
  logic [INH_W-1:0] r_inhCnt;
  logic [TMO_W-1:0] r_tmoCnt;
  logic             r_clkOe;
  logic             r_datOe;
  logic             r_busy;
  logic             r_done;
  logic             r_error;

  logic             w_clkFall;
  logic             w_inhLast;
  logic             w_timeout;

  assign w_clkFall = r_clkPrev & ~r_clkSync;
  assign w_inhLast = (r_inhCnt == INH_W'(INHIBIT_CYCLES - 1));
  assign w_timeout = (r_tmoCnt == TMO_W'(TIMEOUT_CYCLES - 1));

  assign ps2_clk_oe = r_clkOe;
  assign ps2_dat_oe = r_datOe;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;

  // Both lines are idle-high, so the synchronizers reset to 1 to avoid a spurious edge.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      r_clkMeta <= 1'b1;
      r_clkSync <= 1'b1;
      r_clkPrev <= 1'b1;
      r_datMeta <= 1'b1;
      r_datSync <= 1'b1;
    end else begin
      r_clkMeta <= ps2_clk_in;
      r_clkSync <= r_clkMeta;
      r_clkPrev <= r_clkSync;
      r_datMeta <= ps2_din;
      r_datSync <= r_datMeta;
    end
  end

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_data    <= '0;
      r_parity  <= 1'b0;
      r_edgeCnt <= '0;
      r_inhCnt  <= '0;
      r_tmoCnt  <= '0;
      r_clkOe   <= 1'b0;
      r_datOe   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (tx_start) begin
            r_data   <= tx_data;
            r_parity <= ~^tx_data;
            r_busy   <= 1'b1;
            r_clkOe  <= 1'b1;
            r_datOe  <= 1'b0;
            r_inhCnt <= '0;
            r_state  <= INHIBIT;
          end
        end

        INHIBIT: begin
          if (w_inhLast) begin
            r_datOe <= 1'b1;
            r_state <= REQUEST;
          end else begin
            r_inhCnt <= r_inhCnt + 1'b1;
          end
        end

        REQUEST: begin
          r_clkOe   <= 1'b0;
          r_edgeCnt <= '0;
          r_tmoCnt  <= '0;
          r_state   <= SHIFT;
        end

        // r_edgeCnt holds the number of falling edges already seen in this frame.
        SHIFT: begin
          if (w_clkFall) begin
            r_tmoCnt  <= '0;
            r_edgeCnt <= r_edgeCnt + 4'd1;
            if (r_edgeCnt < 4'd8) begin
              r_datOe <= ~r_data[r_edgeCnt[2:0]];
            end else if (r_edgeCnt == 4'd8) begin
              r_datOe <= ~r_parity;
            end else begin
              r_datOe <= 1'b0;
              r_state <= ACK;
            end
          end else if (w_timeout) begin
            r_clkOe <= 1'b0;
            r_datOe <= 1'b0;
            r_busy  <= 1'b0;
            r_error <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_tmoCnt <= r_tmoCnt + 1'b1;
          end
        end

        ACK: begin
          if (w_clkFall) begin
            r_tmoCnt <= '0;
            if (!r_datSync) begin
              r_state <= WAIT_IDLE;
            end else begin
              r_busy  <= 1'b0;
              r_error <= 1'b1;
              r_state <= IDLE;
            end
          end else if (w_timeout) begin
            r_clkOe <= 1'b0;
            r_datOe <= 1'b0;
            r_busy  <= 1'b0;
            r_error <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_tmoCnt <= r_tmoCnt + 1'b1;
          end
        end

        // The device must release both lines before the bus is handed back.
        WAIT_IDLE: begin
          if (r_clkSync && r_datSync) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else if (w_clkFall) begin
            r_tmoCnt <= '0;
          end else if (w_timeout) begin
            r_clkOe <= 1'b0;
            r_datOe <= 1'b0;
            r_busy  <= 1'b0;
            r_error <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_tmoCnt <= r_tmoCnt + 1'b1;
          end
        end

        default: begin
          r_clkOe <= 1'b0;
          r_datOe <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
// tb_ps2_host_tx: PS/2 device model driving ps2_host_tx, with a scoreboard of expected frame outcomes.
// Expected line sequences come from the byte value itself (start, LSB-first data, odd parity, stop).
module tb_ps2_host_tx;

  localparam int INHIBIT  = 1500;
  localparam int TIMEOUT  = 30000;
  localparam int DEV_HALF = 30;
  localparam int M_ACK     = 0;
  localparam int M_NACK    = 1;
  localparam int M_TIMEOUT = 2;
  localparam int M_RESET   = 3;

  typedef struct {
    logic [10:0] bits;
    bit          isDone;
    bit          hasBits;
  } exp_t;

  logic       sys_clock = 1'b0;
  logic       reset     = 1'b1;
  logic       ps2_clk_in;
  logic       ps2_din;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic [7:0] tx_data   = 8'h00;
  logic       tx_start  = 1'b0;
  logic       busy;
  logic       done;
  logic       error;

  logic        devClkLow = 1'b0;
  logic        devDatLow = 1'b0;
  logic [10:0] devBits   = '1;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;

  // Open-collector bus: a line is high only when nobody pulls it down.
  assign ps2_clk_in = ~ps2_clk_oe & ~devClkLow;
  assign ps2_din    = ~ps2_dat_oe & ~devDatLow;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INHIBIT),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .sys_clock (sys_clock),
    .reset     (reset),
    .ps2_clk_in(ps2_clk_in),
    .ps2_din   (ps2_din),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 sys_clock = ~sys_clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
    end
  endtask

  function automatic logic [10:0] refFrame(input logic [7:0] d);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = d[i];
      ones += int'(d[i]);
    end
    f[9]  = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Scoreboard monitor: every done/error pulse consumes exactly one expected outcome.
  always @(negedge sys_clock) begin
    exp_t e;
    if (done === 1'b1 || error === 1'b1) begin
      checkOutput("doneErrorExclusive", 32'(done & error), 32'd0);
      checkOutput("linesAtPulse", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
      checkOutput("busyAtPulse", 32'(busy), 32'd0);
      checkOutput("pulsePending", 32'(expQ.size() > 0), 32'd1);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("outcomeDone", 32'(done), 32'(e.isDone));
        if (e.hasBits) checkOutput("frameBits", 32'(devBits), 32'(e.bits));
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] data, input int mode, input bit poke);
    int   cnt;
    exp_t e;
    bit   aborted;
    aborted = 1'b0;
    @(negedge sys_clock);
    tx_data  = data;
    tx_start = 1'b1;
    e.bits    = refFrame(data);
    e.isDone  = (mode == M_ACK);
    e.hasBits = (mode == M_ACK || mode == M_NACK);
    if (mode != M_RESET) expQ.push_back(e);
    @(negedge sys_clock);
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
    checkOutput("busyAfterStart", 32'(busy), 32'd1);

    cnt = 0;
    while (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b0 && cnt < 5000) begin
      cnt++;
      tx_start = (poke && cnt == 20);
      if (poke && cnt == 20) tx_data = 8'h00;
      @(negedge sys_clock);
    end
    tx_start = 1'b0;
    checkOutput("inhibitLen", 32'(cnt), 32'(INHIBIT));
    checkOutput("requestLines", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b11);
    @(negedge sys_clock);
    checkOutput("shiftEntry", 32'({ps2_clk_oe, ps2_dat_oe, busy}), 32'b011);

    if (mode == M_TIMEOUT) begin
      cnt = 0;
      while (error !== 1'b1 && cnt < TIMEOUT + 100) begin
        @(negedge sys_clock);
        cnt++;
      end
      checkOutput("timeoutLen", 32'(cnt), 32'(TIMEOUT));
    end else begin
      repeat (DEV_HALF) @(negedge sys_clock);
      for (int edgeNum = 1; edgeNum <= 11 && !aborted; edgeNum++) begin
        devBits[edgeNum-1] = ps2_din;
        if (edgeNum == 11 && mode == M_ACK) begin
          devDatLow = 1'b1;
          repeat (5) @(negedge sys_clock);
        end
        devClkLow = 1'b1;
        if (mode == M_RESET && edgeNum == 5) begin
          repeat (DEV_HALF / 2) @(negedge sys_clock);
          reset = 1'b1;
          @(negedge sys_clock);
          checkOutput("resetMidFrame", 32'({ps2_clk_oe, ps2_dat_oe, busy, done, error}), 32'd0);
          reset     = 1'b0;
          devClkLow = 1'b0;
          aborted   = 1'b1;
        end else begin
          repeat (DEV_HALF) @(negedge sys_clock);
          devClkLow = 1'b0;
          repeat (DEV_HALF) @(negedge sys_clock);
          if (edgeNum == 11) devDatLow = 1'b0;
        end
      end
    end

    cnt = 0;
    while (busy !== 1'b0 && cnt < 2000) begin
      @(negedge sys_clock);
      cnt++;
    end
    checkOutput("busyDrop", 32'(busy), 32'd0);
    repeat (20) @(negedge sys_clock);
    checkOutput("idleLines", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
  endtask

  initial begin
    repeat (95000) @(posedge sys_clock);
    $display("[TB] FAIL watchdog: simulation still running at cycle limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] d;
    int         m;
    reset = 1'b1;
    repeat (3) @(negedge sys_clock);
    checkOutput("resetState", 32'({ps2_clk_oe, ps2_dat_oe, busy, done, error}), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge sys_clock);

    applyStimulus(8'hED, M_ACK, 1'b0);
    applyStimulus(8'h01, M_ACK, 1'b0);
    applyStimulus(8'hFF, M_ACK, 1'b0);
    applyStimulus(8'hA5, M_ACK, 1'b1);
    applyStimulus(8'h3C, M_NACK, 1'b0);
    applyStimulus(8'h55, M_RESET, 1'b0);
    applyStimulus(8'hF4, M_ACK, 1'b0);
    applyStimulus(8'h12, M_TIMEOUT, 1'b0);
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      m = ($urandom_range(0, 3) == 0) ? M_NACK : M_ACK;
      applyStimulus(d, m, 1'b0);
    end

    repeat (50) @(negedge sys_clock);
    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 1500, sys_clock cycles the clock line is held low before the request (at least 100 us).
REQ-002 Parameter TIMEOUT_CYCLES, default 30000, maximum sys_clock cycles allowed between device clock falling edges before the frame is abandoned.
REQ-003 sys_clock  in  1  system clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ps2_clk_in  in  1  PS/2 clock line as read back (asynchronous to sys_clock).
REQ-006 ps2_din  in  1  PS/2 data line as read back (asynchronous).
REQ-007 ps2_clk_oe  out  1  1 = pull the clock line low; 0 = release it (open-collector).
REQ-008 ps2_dat_oe  out  1  1 = pull the data line low; 0 = release it.
REQ-009 tx_data  in  8  command byte to send to the keyboard.
REQ-010 tx_start  in  1  one-cycle request; accepted only when busy=0.
REQ-011 busy  out  1  high from acceptance until return to IDLE; the keyboard receiver ignores the lines while it is high.
REQ-012 done  out  1  one-cycle pulse: frame acknowledged by the device.
REQ-013 error  out  1  one-cycle pulse: no acknowledge, or timeout.

Function
REQ-014 ps2_clk_in and ps2_din SHALL each pass through a 2-flop synchronizer; a falling edge is previous-synced=1 and current-synced=0, detected 1 cycle after the second flop.
REQ-015 States SHALL be IDLE, INHIBIT, REQUEST, SHIFT, ACK, WAIT_IDLE.
REQ-016 In IDLE with tx_start=1: latch tx_data, compute odd parity (the XNOR-reduction of tx_data), set busy=1, enter INHIBIT next cycle.
REQ-017 INHIBIT: ps2_clk_oe=1, ps2_dat_oe=0 for exactly INHIBIT_CYCLES cycles, then enter REQUEST.
REQ-018 REQUEST: ps2_dat_oe=1 (start bit), ps2_clk_oe=1 for 1 cycle, then ps2_clk_oe=0; enter SHIFT with edge count 0.
REQ-019 SHIFT: on device clock falling edges 1-8, drive bits 0-7 LSB first (ps2_dat_oe = NOT bit); edge 9 drives parity; edge 10 releases data (stop bit = 1) and enters ACK.
REQ-020 ACK: at the next falling edge (edge 11), sample synced data; 0 → WAIT_IDLE with ack ok; 1 → error pulse, then IDLE.
REQ-021 WAIT_IDLE: wait until synced clock=1 and data=1, then pulse done=1 for 1 cycle and enter IDLE with busy=0 in the same cycle.
REQ-022 The timeout counter SHALL clear on entry to SHIFT and on every falling edge in SHIFT, ACK and WAIT_IDLE; at TIMEOUT_CYCLES: release both lines, pulse error, enter IDLE.
REQ-023 tx_start while busy=1 SHALL be ignored; tx_data is not re-latched.
REQ-024 done and error SHALL never be asserted in the same cycle; exactly one of them pulses per accepted frame (unless reset intervenes).
REQ-025 Outside INHIBIT, REQUEST and SHIFT, ps2_clk_oe=0; outside REQUEST, SHIFT and ACK, ps2_dat_oe=0.

Reset
REQ-026 reset=1 SHALL win over every other input: the next state is IDLE with ps2_clk_oe=0, ps2_dat_oe=0, busy=0, done=0, error=0, counters=0 and synchronizers=1.
REQ-027 Reset mid-frame SHALL release both lines on the next edge with no done/error pulse; a frame in progress is dropped.

Verification
REQ-028 tx_data=0xED, device model clocks at 12.5 kHz and ACKs → data line sequence 0, then 1,0,1,1,0,1,1,1, parity 1, stop 1; done pulses once; error stays 0.
REQ-029 tx_data=0x01, then 0xFF → parity 0, then parity 1; INHIBIT is measured at exactly 1500 cycles with clk low and data released.
REQ-030 Device model leaves data high at edge 11 → error pulses once, done stays 0, busy drops, both oe=0.
REQ-031 Device model never clocks after REQUEST → error exactly 30000 cycles after entry to SHIFT; lines released.
REQ-032 reset asserted at edge 5 of a frame → both oe=0 and busy=0 on the next cycle; a new tx_start=0x F4 then completes normally.
REQ-033 tx_start pulsed again with 0x00 while busy → ignored; the transmitted byte is still the first value, with a single done pulse.
